// File: rtl/uart_tx_mmio_pkg.sv
// uart_mmio_pkg: register offsets, TX FSM states and STATUS layout shared by the UART block
package uart_mmio_pkg;
  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIV    = 2'd2;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_CNT   = 8;
  function automatic logic [31:0] status_word(input logic [7:0] cnt, input logic ovf, busy, empty, full);
    logic [31:0] w;
    w = '0;
    w[ST_CNT +: 8] = cnt;
    w[ST_OVF] = ovf;
    w[ST_BUSY] = busy;
    w[ST_EMPTY] = empty;
    w[ST_FULL] = full;
    return w;
  endfunction
endpackage

// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if: core data-bus store/read stream seen by the UART window
interface uart_tx_mmio_if;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        hit;
  modport master (output we, a, wd, input rd, hit);
  modport slave  (input we, a, wd, output rd, hit);
endinterface

// File: rtl/uart_tx_mmio_fifo_sync.sv
// fifo_sync: power-of-two FIFO with combinational head; a push into a full FIFO is accepted only alongside a pop
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic push_ok, pop_ok;
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign pop_ok = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout = mem_q[rptr_q];
  assign count = count_q;
  // pointer and occupancy update; pointers wrap naturally at DEPTH
  always_comb begin
    wptr_d = wptr_q + AW'(push_ok);
    rptr_d = rptr_q + AW'(pop_ok);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end
  // pointer/occupancy state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
    end
  end
  // storage needs no reset; occupancy guards reads
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= din;
  end
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with TX FIFO, baud divisor and status
module uart_tx_mmio import uart_mmio_pkg::*; #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0080,
  parameter int          DEPTH       = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd3
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_mmio_if.slave bus,
  output logic          tx
);
  localparam int CW = $clog2(DEPTH) + 1;
  tx_state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d, divl_q, divl_d, div_q, div_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d, fifo_dout;
  logic ovf_q, ovf_d, tx_q, tx_d;
  logic [1:0] off;
  logic wr, push, pop, bit_end, start_frame, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  assign off = bus.a[3:2];
  assign bus.hit = bus.a[31:4] == BASE_ADDR[31:4] && off != 2'b11;
  assign wr = bus.we & bus.hit;
  assign push = wr && off == OFF_TXDATA;
  assign bus.rd = !bus.hit ? '0 :
                  off == OFF_STATUS ? status_word(8'(fifo_count), ovf_q, state_q != IDLE, fifo_empty, fifo_full) :
                  off == OFF_DIV ? {16'b0, div_q} : '0;
  assign tx = tx_q;
  fifo_sync #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(bus.wd[7:0]),
    .dout(fifo_dout), .count(fifo_count), .full(fifo_full), .empty(fifo_empty)
  );
  // divisor register and sticky overflow flag (cleared by any STATUS write)
  always_comb begin
    div_d = wr && off == OFF_DIV ? bus.wd[15:0] : div_q;
    ovf_d = wr && off == OFF_STATUS ? 1'b0 : push && fifo_full && !pop ? 1'b1 : ovf_q;
  end
  // frame sequencer: a new frame loads from IDLE or straight out of STOP so queued bytes leave no gap
  always_comb begin
    bit_end = cnt_q == '0;
    start_frame = !fifo_empty && (state_q == IDLE || (state_q == STOP && bit_end));
    state_d = state_q;
    cnt_d = state_q == IDLE ? cnt_q : bit_end ? divl_q : cnt_q - 16'd1;
    idx_d = idx_q;
    sh_d = sh_q;
    divl_d = divl_q;
    tx_d = tx_q;
    pop = start_frame;
    case (state_q)
      START: if (bit_end) begin
        state_d = DATA;
        idx_d = '0;
        tx_d = sh_q[0];
      end
      DATA: if (bit_end) begin
        if (idx_q == 3'd7) begin
          state_d = STOP;
          tx_d = 1'b1;
        end else begin
          sh_d = sh_q >> 1;
          idx_d = idx_q + 3'd1;
          tx_d = sh_q[1];
        end
      end
      STOP: if (bit_end) begin
        state_d = IDLE;
        tx_d = 1'b1;
      end
      default: ;
    endcase
    if (start_frame) begin
      state_d = START;
      sh_d = fifo_dout;
      divl_d = div_q;
      cnt_d = div_q;
      tx_d = 1'b0;
    end
  end
  // registered state; reset returns the line high at once, even mid-frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      divl_q <= DEFAULT_DIV;
      div_q <= DEFAULT_DIV;
      ovf_q <= 1'b0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      divl_q <= divl_d;
      div_q <= div_d;
      ovf_q <= ovf_d;
      tx_q <= tx_d;
    end
  end
endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the single-cycle core's data bus, in parallel with dmem.
- Consumes the core's MemWrite/DataAdr/WriteData store stream and supplies read data for its own address window.
- Buffers bytes in a TX FIFO and serialises them 8N1, LSB first, on tx.
- Exposes a combinational hit so top can select rd over dmem ReadData.

Parameters:
- BASE_ADDR, 32'h0000_0080, word-aligned base of the 3-register window (0x80/0x84/0x88).
- DEPTH, 8, TX FIFO entries; power of two, 2..256.
- DEFAULT_DIV, 16'd3, reset value of the baud divisor.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- we  input  1  core MemWrite
- a  input  32  core DataAdr (byte address)
- wd  input  32  core WriteData
- rd  output  32  combinational read data; 0 when hit=0
- hit  output  1  combinational; a[31:4]==BASE_ADDR[31:4] and a[3:2]!=2'b11
- tx  output  1  serial line; idle high, registered

Behaviour:
- Reset: clk is the clock; reset is asynchronous, active-high. Reset clears the FIFO (count=0), state=IDLE, tx=1, div=DEFAULT_DIV and ovf=0. Behaviour is identical if reset lands mid-frame; tx returns high immediately.
- Register map (offset a[3:2]):
  - 0 TXDATA, W: push wd[7:0]; reads as 0.
  - 1 STATUS: R {16'b0, count[7:0], 4'b0, ovf, busy, empty, full}. Any write clears ovf.
  - 2 DIV: RW, low 16 bits; upper bits read 0.
- Reads are combinational, same cycle, matching dmem timing. Writes take effect at the posedge where we & hit.
- Accesses with hit=0 have no effect and rd=0. The a[1:0] bits are ignored.
- Push rule: accepted if count<DEPTH, or if a pop occurs on the same edge (count unchanged). Otherwise the byte is dropped and ovf is set (sticky).
- full = (count==DEPTH); empty = (count==0); busy = (state!=IDLE).
- FSM states: IDLE, START, DATA, STOP. One bit period = div_latched+1 cycles, counted by a 16-bit down counter.
  - IDLE: tx=1. At an edge where !empty: pop the head into shifter, latch div into div_latched, go to START; tx=0 from that edge.
  - START: after one bit period go to DATA with bit index 0; tx=shifter[0].
  - DATA: at each period end shift right, index+1. After index 7 completes go to STOP; tx=1.
  - STOP: after one bit period, if !empty pop and go to START (back-to-back, no idle gap); else go to IDLE.
- A frame lasts 10*(div+1) cycles. div=0 gives 1 cycle/bit.
- A DIV write mid-frame affects only the next frame, because div_latched is held per frame.
- A push into an empty FIFO in IDLE starts the frame on the following edge, so tx falls 1 cycle after the store edge.
- FIFO pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1, zero-extended into STATUS[15:8].

Decomposition:
- Package uart_mmio_pkg holds:
  - offsets OFF_TXDATA=2'd0, OFF_STATUS=2'd1, OFF_DIV=2'd2;
  - typedef enum logic [1:0] tx_state_t {IDLE, START, DATA, STOP};
  - STATUS bit-position constants.
- One sub-module: fifo_sync (WIDTH, DEPTH) with push, pop, din, dout (head, combinational), count, full, empty, and async reset. The top level holds decode, registers, FSM and bit counter.

Test Plan:
- Reset, then read 0x84 -> rd=32'h0000_0002 (empty=1); tx=1; read 0x88 -> 3.
- Write 0x55 to 0x80 with div=3 -> tx falls 1 cycle later. Every 4 cycles tx shows 0,1,0,1,0,1,0,1,0,1, then returns to idle. busy=1 for 40 cycles.
- Write 9 bytes back-to-back with div=100:
  - first pops immediately;
  - after 9 writes count=8, full=1;
  - a 10th write drops the byte and STATUS reads 0x0000_080D (count=8, ovf, busy, full);
  - a write to 0x84 clears ovf.
- Two queued bytes 0xA0, 0x0F, div=0 -> 20 consecutive cycles of frames with no idle cycle between STOP and the second START.
- Write DIV=7 mid-frame with div=3 -> current frame keeps 4 cycles/bit; the next frame uses 8 cycles/bit.
- Assert reset mid-DATA bit 4 -> tx=1 immediately and the FIFO is empty. After release STATUS=0x2 and div=3. Accesses at a=0x8C or 0x64 -> hit=0, rd=0, no state change.
